// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared types and default sizing for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int DEF_DATA_WIDTH   = 16;
    localparam int DEF_ADDR_WIDTH   = 5;
    localparam int DEF_AFULL_MARGIN = 4;

    // Output stage: EMPTY has no head word on rd_data, VALID holds one.
    typedef enum logic {
        EMPTY = 1'b0,
        VALID = 1'b1
    } state_e;

endpackage

// File: rtl/single_port_ram.sv
// Simple RAM with separate read/write addresses and a registered read address
// (one cycle read latency, no reset on storage).
module single_port_ram #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wraddr,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic [ADDR_WIDTH-1:0] rdaddr,
    output logic [DATA_WIDTH-1:0] q
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] rdaddr_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wraddr] <= wrdata;
        end
        rdaddr_q <= rdaddr;
    end

    assign q = mem[rdaddr_q];

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller over a 1-cycle-latency RAM: the head word is prefetched into
// the RAM output so rd_data is valid whenever rd_valid is high.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int AFULL_LEVEL = (2**ADDR_WIDTH) - DEF_AFULL_MARGIN
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic                  rd_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam int DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   AFULL_C = (ADDR_WIDTH+1)'(AFULL_LEVEL);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   pending_q, pending_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;

    logic                  push, pop, fetch, we;
    logic [ADDR_WIDTH-1:0] rdaddr;

    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= AFULL_C);
    assign count       = count_q;
    assign wr_ready    = !full;
    assign rd_valid    = (state_q == VALID);

    assign push  = wr_valid & wr_ready;
    assign pop   = rd_valid & rd_ready;
    assign fetch = (pending_q != '0) && ((state_q == EMPTY) || pop);
    assign we    = push & ~flush & rst_n;

    // Without a fetch, keep re-reading the current head (one behind rd_ptr)
    // so rd_data stays stable while the consumer stalls.
    assign rdaddr = fetch ? rd_ptr_q : (rd_ptr_q - PTR_ONE);

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        pending_d = pending_q;
        count_d   = count_q;
        if (flush) begin
            state_d   = EMPTY;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            pending_d = '0;
            count_d   = '0;
        end else begin
            if (push)  wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (fetch) rd_ptr_d = rd_ptr_q + PTR_ONE;

            case ({push, fetch})
                2'b10:   pending_d = pending_q + CNT_ONE;
                2'b01:   pending_d = pending_q - CNT_ONE;
                default: pending_d = pending_q;
            endcase

            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase

            case (state_q)
                EMPTY:   if (fetch)        state_d = VALID;
                VALID:   if (pop && !fetch) state_d = EMPTY;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    single_port_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (we),
        .wraddr (wr_ptr_q),
        .wrdata (wr_data),
        .rdaddr (rdaddr),
        .q      (rd_data)
    );

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Scoreboard bench for ram_fifo_ctrl: a negedge monitor tracks occupancy and
// expected data order; directed sequences cover latency, fill, wrap, flush, reset.
module tb_ram_fifo_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;
    localparam int AFL   = 28;

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          flush    = 1'b0;
    logic          wr_valid = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          rd_ready = 1'b0;
    logic          wr_ready, rd_valid, full, empty, almost_full;
    logic [DW-1:0] rd_data;
    logic [AW:0]   count;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            n_pop  = 0;
    int            m_cnt  = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .AFULL_LEVEL (AFL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int budget);
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < budget && !empty; i++) cyc();
        rd_ready = 1'b0;
        chk("drain_empty", empty, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_wr_ready"}, wr_ready, 1);
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_full"}, full, 0);
        chk({tag, "_afull"}, almost_full, 0);
        chk({tag, "_count"}, count, 0);
    endtask

    // Model: compare flags against tracked occupancy, then apply the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        logic          push_m, pop_m;
        logic [DW-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            m_cnt = 0;
        end else begin
            chk("mon_count", count, m_cnt);
            chk("mon_empty", empty, m_cnt == 0);
            chk("mon_full", full, m_cnt == DEPTH);
            chk("mon_afull", almost_full, m_cnt >= AFL);
            chk("mon_wr_ready", wr_ready, m_cnt != DEPTH);
            chk("mon_rv_without_data", rd_valid && (exp_q.size() == 0), 0);
            if (flush) begin
                exp_q.delete();
                m_cnt = 0;
            end else begin
                pop_m  = rd_valid && rd_ready;
                push_m = wr_valid && (m_cnt != DEPTH);
                if (pop_m) begin
                    n_pop++;
                    if (exp_q.size() == 0) chk("mon_pop_underflow", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("mon_rd_data", rd_data, e);
                    end
                end
                if (push_m) exp_q.push_back(wr_data);
                m_cnt = m_cnt + int'(push_m) - int'(pop_m);
            end
        end
    end

    initial begin
        int p0;

        #12;
        chk_reset_outputs("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();

        // Single word: rd_valid two cycles after the push is presented
        wr_valid = 1'b1;
        wr_data  = 16'h1234;
        cyc();
        wr_valid = 1'b0;
        chk("single_rv_c1", rd_valid, 0);
        cyc();
        chk("single_rv_c2", rd_valid, 1);
        chk("single_data", rd_data, 16'h1234);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("single_empty", empty, 1);
        chk("single_count", count, 0);

        // Pop requests on an empty FIFO are ignored
        rd_ready = 1'b1;
        repeat (3) cyc();
        rd_ready = 1'b0;
        chk("idle_pop_count", count, 0);
        chk("idle_pop_rv", rd_valid, 0);

        // Fill to full, 33rd push rejected
        for (int i = 0; i < 33; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(i);
            cyc();
            if (i == 26) chk("fill_afull_27", almost_full, 0);
            if (i == 27) chk("fill_afull_28", almost_full, 1);
        end
        wr_valid = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_wr_ready", wr_ready, 0);
        chk("fill_count", count, 32);

        // Full with simultaneous pop and push: only the pop is taken
        rd_ready = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hBAD0;
        cyc();
        rd_ready = 1'b0;
        wr_valid = 1'b0;
        chk("fullpop_count", count, 31);
        chk("fullpop_wr_ready", wr_ready, 1);
        drain(64);

        // Streaming: after the prime, one output word held plus one in flight
        p0 = n_pop;
        rd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(16'h0100 + i);
            cyc();
            if (i >= 1) begin
                chk("stream_count", count, 2);
                chk("stream_rv", rd_valid, 1);
            end
        end
        drain(16);
        chk("stream_pops", n_pop - p0, 100);

        // Wrap: three rounds of 20 in / 20 out
        p0 = n_pop;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 20; i++) begin
                wr_valid = 1'b1;
                wr_data  = DW'(16'h2000 + r * 20 + i);
                cyc();
            end
            drain(40);
        end
        chk("wrap_pops", n_pop - p0, 60);

        // Flush beats a same-cycle push
        for (int i = 0; i < 10; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(16'h3000 + i);
            cyc();
        end
        wr_valid = 1'b0;
        chk("flush_pre_count", count, 10);
        flush    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = 16'hDEAD;
        cyc();
        flush    = 1'b0;
        wr_valid = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_rv", rd_valid, 0);
        cyc();
        chk("flush_no_write_rv", rd_valid, 0);
        wr_valid = 1'b1;
        wr_data  = 16'hBEEF;
        cyc();
        drain(8);

        // Reset mid-stream, then a push on the first edge after release
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = DW'(16'h4000 + i);
            cyc();
        end
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("midrst");
        rd_ready = 1'b0;
        wr_data  = 16'h5555;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc();
        wr_valid = 1'b0;
        chk("post_rst_push", count, 1);
        drain(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
